// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises, latches, masks and prioritises source lines,
// and presents one one-hot interrupt to the core until end-of-interrupt.
module irq_ctrl #(
  parameter int N_IRQ       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_IRQ-1:0] src_irq,
  output logic [31:0]      irq,
  input  logic             eoi,
  input  logic             cfg_we,
  input  logic             cfg_re,
  input  logic [3:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             cfg_rvalid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] s, s_d_q, edge_det;
  logic [N_IRQ-1:0] enable_q, edge_sel_q, pending_q, pending_d;
  logic [N_IRQ-1:0] w1c, eoi_clr, req;
  logic [1:0]       state_q, state_d;
  logic [31:0]      irq_q, irq_d, rdata_d, rdata_q;
  logic [31:0]      en32, es32, pend32;
  logic [4:0]       id_q, id_d, sel;
  logic             rvalid_q, eoi_act;
  logic             wr_en, wr_es, wr_pend;
  logic             unused_bits;

  assign unused_bits = ^{cfg_addr[1:0], cfg_wdata};

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~s_d_q;
  assign wr_en    = cfg_we && (cfg_addr[3:2] == 2'd0);
  assign wr_es    = cfg_we && (cfg_addr[3:2] == 2'd1);
  assign wr_pend  = cfg_we && (cfg_addr[3:2] == 2'd2);
  assign eoi_act  = eoi && (state_q == S_ACTIVE);
  assign w1c      = wr_pend ? cfg_wdata[N_IRQ-1:0] : '0;

  // Edge-mode bits: a new edge beats any clear in the same cycle; level bits follow s.
  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < N_IRQ; i++) eoi_clr[i] = eoi_act && (id_q == 5'(i));
    pending_d = (edge_sel_q & (edge_det | (pending_q & ~(w1c | eoi_clr))))
              | (~edge_sel_q & s);
  end

  always_comb begin
    req = pending_q & enable_q;
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          id_d    = sel;
          irq_d   = 32'd1 << sel;
          state_d = S_ACTIVE;
        end else begin
          irq_d = '0;
        end
      end
      S_ACTIVE: begin
        if (eoi) begin
          irq_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        irq_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        irq_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    en32   = '0;
    es32   = '0;
    pend32 = '0;
    en32[N_IRQ-1:0]   = enable_q;
    es32[N_IRQ-1:0]   = edge_sel_q;
    pend32[N_IRQ-1:0] = pending_q;
    rdata_d = '0;
    if (cfg_re) begin
      case (cfg_addr[3:2])
        2'd0: rdata_d = en32;
        2'd1: rdata_d = es32;
        2'd2: rdata_d = pend32;
        default: rdata_d = (state_q == S_ACTIVE) ? {1'b1, 26'd0, id_q} : 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d_q      <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      pending_q  <= '0;
      state_q    <= S_IDLE;
      irq_q      <= '0;
      id_q       <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      sync_q[0] <= src_irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d_q     <= s;
      if (wr_en) enable_q <= cfg_wdata[N_IRQ-1:0];
      if (wr_es) edge_sel_q <= cfg_wdata[N_IRQ-1:0];
      pending_q <= pending_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
      id_q      <= id_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= cfg_re;
    end
  end

  assign irq        = irq_q;
  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller between peripheral interrupt sources and the core's `irq[31:0]` / `eoi` pair.
- Synchronises, latches, masks and prioritises up to 32 source lines.
- Presents exactly one active interrupt to the core at a time, one-hot, and holds it until the core signals end-of-interrupt.
- Configured by a small register port driven from the peripheral bus decoder.

Parameters:
- N_IRQ, 32, number of source lines (1..32); unused upper bits of every 32-bit register read 0 and ignore writes.
- SYNC_STAGES, 2, synchroniser flops per source line (2..3).

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- src_irq  input  N_IRQ  raw peripheral interrupt lines, asynchronous to clk
- irq  output  32  one-hot interrupt to core; all-zero when none active
- eoi  input  1  single-cycle end-of-interrupt pulse from core
- cfg_we  input  1  register write strobe
- cfg_re  input  1  register read strobe
- cfg_addr  input  4  byte address; bits [1:0] ignored
- cfg_wdata  input  32  write data
- cfg_rdata  output  32  read data, valid when cfg_rvalid is high
- cfg_rvalid  output  1  one-cycle pulse, the cycle after cfg_re

Behaviour:
- Reset: clk is the only clock. resetn is asynchronous and active-low. While resetn is low, all of the following are 0:
  - irq, cfg_rdata, cfg_rvalid
  - ENABLE, EDGE_SEL, PENDING
  - synchroniser and edge history flops
  - FSM forced to IDLE
  Reset mid-interrupt drops irq immediately, without waiting for a clock edge.
- Registers:
  - 0x0 ENABLE (RW): per-source mask, 1 = enabled.
  - 0x4 EDGE_SEL (RW): 1 = rising-edge mode, 0 = level mode.
  - 0x8 PENDING (R, W1C): write-1-to-clear applies to edge-mode bits only; level-mode bits ignore clears.
  - 0xC ACTIVE: bit31 = an interrupt is active; bits[4:0] = active id; others 0.
  - Other addresses read 0; writes to them are ignored.
  - Writes take effect at the next clk edge. Reads are registered: cfg_rdata/cfg_rvalid appear one cycle after cfg_re.
- Synchronisation: each src_irq bit passes through SYNC_STAGES flops, giving s[i]. Edge detect = s[i] & ~s_d[i].
- Pending update, every cycle:
  - Edge mode: pending[i] sets on a detected edge and clears on W1C or on eoi for the active id. If set and clear occur in the same cycle, set wins.
  - Level mode: pending[i] = s[i], registered.
  - Pending is recorded regardless of ENABLE.
- Latency: src_irq rising edge sampled at clk edge k -> s at k+SYNC_STAGES-1 -> pending at k+SYNC_STAGES -> irq at k+SYNC_STAGES+1 when the FSM is IDLE. With defaults, irq rises 3 edges after sampling.
- FSM states IDLE, ACTIVE, GAP:
  - IDLE: if (pending & ENABLE) != 0, select the lowest index id, register irq = 1<<id, go ACTIVE. Otherwise irq = 0.
  - ACTIVE:
    - irq is held constant.
    - Changes to ENABLE, EDGE_SEL or source deassertion do not drop irq.
    - W1C of the active id clears its pending bit but keeps irq asserted until eoi.
    - On eoi: irq <= 0; if the active id is in edge mode, clear its pending bit (subject to set-wins); go GAP.
  - GAP: one cycle with irq = 0, to guarantee a visible deassertion. Then go IDLE.
- An eoi received in IDLE or GAP is ignored.
- A level source still high after eoi re-triggers: irq reasserts 2 cycles after eoi (GAP, then IDLE selection).
- Priority is fixed (0 highest). There is no nesting or preemption: a higher-priority request arriving during ACTIVE waits for eoi.

Test Plan:
- Reset release, ENABLE=0x1, EDGE_SEL=0x1, pulse src_irq[0] high for 1 cycle -> irq=0x00000001 exactly 3 edges after the sampling edge. ACTIVE reads 0x80000000. eoi -> irq=0, then stays 0, and PENDING reads 0.
- ENABLE=0xFFFFFFFF, EDGE_SEL=0xFFFFFFFF, edges on src 5 and 3 in the same cycle -> irq=0x8 first. eoi -> 1 GAP cycle -> irq=0x20. ACTIVE reads 0x80000005.
- Level mode, src_irq[7] held high, ENABLE=0x80 -> irq=0x80. eoi -> irq=0 for 2 cycles, then 0x80 again. Drop src_irq[7], then eoi -> irq stays 0.
- Edge mode on src 2, new edge arriving in the same cycle as eoi for id 2 -> PENDING bit 2 stays 1 and irq=0x4 reasserts after GAP.
- ENABLE=0, edge on src 4 -> PENDING=0x10, irq=0. Write PENDING=0x10 -> PENDING=0. Write ENABLE=0x10 -> irq stays 0.
- irq=0x1 active, pull resetn low between clock edges -> irq=0 asynchronously. After release, all registers read 0.
